// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one single-port synchronous RAM
//
// Purpose: shares one 1-cycle-latency single-port RAM between instruction fetch
// (I side) and load/store (D side). Data has priority. The starvation counter
// hands the port to a pending fetch after STARVE_MAX consecutive data grants.
//
// Optional feature: define ARB_PERF_CNT_EN to add the stall-cycle counters
// r_i_stall_cnt / r_d_stall_cnt.
//
// Ports:
//   w_clk, w_rst         clock, synchronous active-high reset
//   w_i_req/addr         fetch request and word address
//   w_i_gnt, w_i_stall   fetch granted / fetch waiting (combinational)
//   r_i_valid, w_i_rdata fetch read data, one cycle after the grant
//   w_d_req/we/addr/wdata data request (we=1 store, we=0 load)
//   w_d_gnt, w_d_stall   data granted / data waiting (combinational)
//   r_d_valid, w_d_rdata load read data, one cycle after the grant
//   w_m_addr/we/wdata    RAM command
//   w_m_rdata            RAM registered read data
//   r_i_stall_cnt, r_d_stall_cnt  stall-cycle counters (ARB_PERF_CNT_EN only)
module mem_port_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_i_req,
  input  logic [ADDR_W-1:0] w_i_addr,
  output logic              w_i_gnt,
  output logic              w_i_stall,
  output logic              r_i_valid,
  output logic [DATA_W-1:0] w_i_rdata,
  input  logic              w_d_req,
  input  logic              w_d_we,
  input  logic [ADDR_W-1:0] w_d_addr,
  input  logic [DATA_W-1:0] w_d_wdata,
  output logic              w_d_gnt,
  output logic              w_d_stall,
  output logic              r_d_valid,
  output logic [DATA_W-1:0] w_d_rdata,
  output logic [ADDR_W-1:0] w_m_addr,
  output logic              w_m_we,
  output logic [DATA_W-1:0] w_m_wdata,
  input  logic [DATA_W-1:0] w_m_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       r_i_stall_cnt,
  output logic [31:0]       r_d_stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_IRD, S_DRD, S_DWR} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            r_state;
  state_t            state_next;
  logic [3:0]        r_starve;
  logic [3:0]        starve_next;
  logic              starve_hit;
  logic [ADDR_W-1:0] r_last_addr;

  assign starve_hit = (r_starve >= STARVE_LIM);

  always_comb begin
    w_i_gnt     = 1'b0;
    w_d_gnt     = 1'b0;
    state_next  = S_IDLE;
    starve_next = r_starve;

    if (!w_rst) begin
      if (w_i_req && (!w_d_req || starve_hit)) begin
        w_i_gnt = 1'b1;
      end else if (w_d_req) begin
        w_d_gnt = 1'b1;
      end
    end

    if (w_i_gnt) begin
      state_next = S_IRD;
    end else if (w_d_gnt) begin
      state_next = w_d_we ? S_DWR : S_DRD;
    end

    // Count only data grants that overtake a waiting fetch; saturate at the limit.
    if (w_i_gnt || !w_i_req) begin
      starve_next = 4'd0;
    end else if (w_d_gnt && !starve_hit) begin
      starve_next = r_starve + 4'd1;
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state  <= S_IDLE;
      r_starve <= 4'd0;
    end else begin
      r_state  <= state_next;
      r_starve <= starve_next;
    end
  end

  // Issued address is kept across idle cycles so the RAM address stays stable.
  always_ff @(posedge w_clk) begin
    if (w_i_gnt) begin
      r_last_addr <= w_i_addr;
    end else if (w_d_gnt) begin
      r_last_addr <= w_d_addr;
    end
  end

  assign w_i_stall = w_i_req && !w_i_gnt;
  assign w_d_stall = w_d_req && !w_d_gnt;

  assign w_m_addr  = w_i_gnt ? w_i_addr : (w_d_gnt ? w_d_addr : r_last_addr);
  assign w_m_we    = w_d_gnt && w_d_we;
  assign w_m_wdata = w_d_wdata;

  // Valid follows the access recorded last cycle; a reset in the return cycle
  // drops the in-flight read.
  assign r_i_valid = (r_state == S_IRD) && !w_rst;
  assign r_d_valid = (r_state == S_DRD) && !w_rst;
  assign w_i_rdata = w_m_rdata;
  assign w_d_rdata = w_m_rdata;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_i_stall_cnt <= 32'd0;
      r_d_stall_cnt <= 32'd0;
    end else begin
      if (w_i_stall) r_i_stall_cnt <= r_i_stall_cnt + 32'd1;
      if (w_d_stall) r_d_stall_cnt <= r_d_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW   = 11;
  localparam int DW   = 32;
  localparam int SMAX = 3;

  logic          w_clk = 1'b0;
  logic          w_rst;
  logic          w_i_req;
  logic [AW-1:0] w_i_addr;
  logic          w_i_gnt, w_i_stall, r_i_valid;
  logic [DW-1:0] w_i_rdata;
  logic          w_d_req, w_d_we;
  logic [AW-1:0] w_d_addr;
  logic [DW-1:0] w_d_wdata;
  logic          w_d_gnt, w_d_stall, r_d_valid;
  logic [DW-1:0] w_d_rdata;
  logic [AW-1:0] w_m_addr;
  logic          w_m_we;
  logic [DW-1:0] w_m_wdata;
  logic [DW-1:0] w_m_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]   r_i_stall_cnt, r_d_stall_cnt;
`endif

  always #5 w_clk = ~w_clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .w_clk(w_clk), .w_rst(w_rst),
    .w_i_req(w_i_req), .w_i_addr(w_i_addr), .w_i_gnt(w_i_gnt),
    .w_i_stall(w_i_stall), .r_i_valid(r_i_valid), .w_i_rdata(w_i_rdata),
    .w_d_req(w_d_req), .w_d_we(w_d_we), .w_d_addr(w_d_addr), .w_d_wdata(w_d_wdata),
    .w_d_gnt(w_d_gnt), .w_d_stall(w_d_stall), .r_d_valid(r_d_valid), .w_d_rdata(w_d_rdata),
    .w_m_addr(w_m_addr), .w_m_we(w_m_we), .w_m_wdata(w_m_wdata), .w_m_rdata(w_m_rdata)
`ifdef ARB_PERF_CNT_EN
    , .r_i_stall_cnt(r_i_stall_cnt), .r_d_stall_cnt(r_d_stall_cnt)
`endif
  );

  function automatic logic [DW-1:0] init_word(input int k);
    return 32'hA500_0000 | 32'(k);
  endfunction

  // Write-first single-port RAM with registered read.
  logic [DW-1:0] ram [0:2047];
  bit            ram_ready = 1'b0;
  always @(posedge w_clk) begin
    if (!ram_ready) begin
      for (int k = 0; k < 2048; k++) ram[k] <= init_word(k);
      ram_ready <= 1'b1;
    end else if (w_m_we) begin
      ram[w_m_addr] <= w_m_wdata;
      w_m_rdata     <= w_m_wdata;
    end else begin
      w_m_rdata <= ram[w_m_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words written so far, pending read returns, starvation run length.
  logic [DW-1:0] mdl_mem [int];
  int            m_starve = 0;
  bit            m_pi = 1'b0, m_pd = 1'b0;
  logic [DW-1:0] m_pi_data, m_pd_data;
  logic [AW-1:0] m_last;
  bit            m_last_ok = 1'b0;
  logic [31:0]   m_icnt = 0, m_dcnt = 0;

  function automatic logic [DW-1:0] mdl_read(input int a);
    return mdl_mem.exists(a) ? mdl_mem[a] : init_word(a);
  endfunction

  always @(negedge w_clk) begin
    bit egi, egd;
    egi = 1'b0;
    egd = 1'b0;
    if (!w_rst) begin
      if (w_i_req && w_d_req) begin
        if (m_starve >= SMAX) egi = 1'b1;
        else                  egd = 1'b1;
      end else if (w_i_req) egi = 1'b1;
      else if (w_d_req)     egd = 1'b1;
    end
    chk("i_gnt", w_i_gnt, egi);
    chk("d_gnt", w_d_gnt, egd);
    chk("i_stall", w_i_stall, w_i_req && !egi);
    chk("d_stall", w_d_stall, w_d_req && !egd);
    chk("i_valid", r_i_valid, m_pi && !w_rst);
    chk("d_valid", r_d_valid, m_pd && !w_rst);
    if (m_pi && !w_rst) chk("i_rdata", w_i_rdata, m_pi_data);
    if (m_pd && !w_rst) chk("d_rdata", w_d_rdata, m_pd_data);
    chk("m_we", w_m_we, egd && w_d_we);
    if (egi)            chk("m_addr_i", w_m_addr, w_i_addr);
    else if (egd)       chk("m_addr_d", w_m_addr, w_d_addr);
    else if (m_last_ok) chk("m_addr_hold", w_m_addr, m_last);
    if (egd && w_d_we)  chk("m_wdata", w_m_wdata, w_d_wdata);
`ifdef ARB_PERF_CNT_EN
    chk("i_stall_cnt", r_i_stall_cnt, m_icnt);
    chk("d_stall_cnt", r_d_stall_cnt, m_dcnt);
`endif
    if (w_rst) begin
      m_starve = 0;
      m_pi     = 1'b0;
      m_pd     = 1'b0;
      m_icnt   = 0;
      m_dcnt   = 0;
    end else begin
      m_pi = egi;
      m_pd = egd && !w_d_we;
      if (egi)            m_pi_data = mdl_read(int'(w_i_addr));
      if (egd && !w_d_we) m_pd_data = mdl_read(int'(w_d_addr));
      if (egd && w_d_we)  mdl_mem[int'(w_d_addr)] = w_d_wdata;
      if (egi || !w_i_req) m_starve = 0;
      else if (egd)        m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
      if (w_i_req && !egi) m_icnt++;
      if (w_d_req && !egd) m_dcnt++;
    end
    if (egi) begin
      m_last = w_i_addr;
      m_last_ok = 1'b1;
    end else if (egd) begin
      m_last = w_d_addr;
      m_last_ok = 1'b1;
    end
  end

  // One cycle of stimulus; returns just after the following negedge.
  task automatic cyc(input bit rst, input bit ir, input logic [AW-1:0] ia,
                     input bit dr, input bit dwe, input logic [AW-1:0] da,
                     input logic [DW-1:0] dwd);
    @(posedge w_clk);
    #1;
    w_rst     = rst;
    w_i_req   = ir;
    w_i_addr  = ia;
    w_d_req   = dr;
    w_d_we    = dwe;
    w_d_addr  = da;
    w_d_wdata = dwd;
    @(negedge w_clk);
    #1;
  endtask

  logic [0:9] pat10 = 10'b1110111011;
  logic [0:3] pat4  = 4'b1110;

  initial begin
    w_rst = 1'b1; w_i_req = 1'b0; w_i_addr = '0;
    w_d_req = 1'b0; w_d_we = 1'b0; w_d_addr = '0; w_d_wdata = '0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst_i_valid", r_i_valid, 1'b0);
    chk("rst_d_valid", r_d_valid, 1'b0);
    chk("rst_gnt", {w_i_gnt, w_d_gnt}, 2'b00);

    // Fetch-only stream
    for (int c = 0; c < 4; c++) begin
      cyc(0, 1, AW'(c), 0, 0, 0, 0);
      chk("p1_gnt", w_i_gnt, 1'b1);
      chk("p1_stall", w_i_stall, 1'b0);
      chk("p1_valid", r_i_valid, c > 0);
      if (c > 0) chk("p1_rdata", w_i_rdata, 32'hA500_0000 + 32'(c - 1));
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("p1_valid_last", r_i_valid, 1'b1);
    chk("p1_rdata_last", w_i_rdata, 32'hA500_0003);

    // Store then load same address
    cyc(0, 0, 0, 1, 1, 11'h010, 32'hDEAD_BEEF);
    chk("p3_st_gnt", w_d_gnt, 1'b1);
    chk("p3_st_we", w_m_we, 1'b1);
    cyc(0, 0, 0, 1, 0, 11'h010, 32'h0);
    chk("p3_no_valid_after_store", r_d_valid, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("p3_ld_valid", r_d_valid, 1'b1);
    chk("p3_ld_data", w_d_rdata, 32'hDEAD_BEEF);

    // Fetch grant, then reset during its return cycle
    cyc(0, 1, 11'd5, 0, 0, 0, 0);
    chk("p4_gnt", w_i_gnt, 1'b1);
    cyc(1, 1, 11'd6, 1, 0, 11'd7, 0);
    chk("p4_valid_rst", r_i_valid, 1'b0);
    chk("p4_gnt_rst", {w_i_gnt, w_d_gnt}, 2'b00);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("p4_valid_after", r_i_valid, 1'b0);

    // Both requests held: D,D,D,I,...
    for (int k = 0; k < 10; k++) begin
      cyc(0, 1, AW'(k), 1, 0, AW'(k + 100), 0);
      chk("p2_dgnt", w_d_gnt, pat10[k]);
      chk("p2_istall", w_i_stall, pat10[k]);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
`ifdef ARB_PERF_CNT_EN
    chk("p2_i_stall_cnt", r_i_stall_cnt, 32'd8);
    chk("p2_d_stall_cnt", r_d_stall_cnt, 32'd2);
`endif

    // Data alone, then fetch joins
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 1, 0, AW'(k + 200), 0);
      chk("p5_dgnt", w_d_gnt, 1'b1);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, AW'(k + 300), 1, 0, AW'(k + 200), 0);
      chk("p5_igrant", w_i_gnt, !pat4[k]);
    end

    // Randomized traffic over a small address window to exercise RAW
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 63) == 0,
          $urandom_range(0, 3) != 0, AW'($urandom_range(0, 15)),
          $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
          AW'($urandom_range(0, 15)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous 2048x32 RAM (1-cycle read latency, write on clock edge) between the IF stage (instruction fetch) and the MEM stage (lw/sw) of the 5-stage pipeline.
- Issues at most one memory access per cycle, returns read data with a valid strobe, and drives per-requester stall outputs.
- The pipeline uses these stall outputs as an interlock source.
- Data side has priority, bounded by a starvation limit so fetch always progresses.

Parameters:
- ADDR_W, 11, word-address width (2048 words).
- DATA_W, 32, data width.
- STARVE_MAX, 3, maximum consecutive data grants while a fetch is pending; range 1..15.

Ports:
- w_clk  in  1  clock; all state updates on posedge.
- w_rst  in  1  synchronous reset, active-high.
- w_i_req  in  1  fetch request; held until granted.
- w_i_addr  in  ADDR_W  fetch word address.
- w_i_gnt  out  1  fetch granted this cycle (combinational).
- w_i_stall  out  1  w_i_req && !w_i_gnt.
- r_i_valid  out  1  fetch data valid (registered).
- w_i_rdata  out  DATA_W  fetch data; meaningful only when r_i_valid.
- w_d_req  in  1  data request; held until granted.
- w_d_we  in  1  1 = store, 0 = load.
- w_d_addr  in  ADDR_W  data word address.
- w_d_wdata  in  DATA_W  store data.
- w_d_gnt  out  1  data granted this cycle (combinational).
- w_d_stall  out  1  w_d_req && !w_d_gnt.
- r_d_valid  out  1  load data valid (registered; never set for stores).
- w_d_rdata  out  DATA_W  load data; meaningful only when r_d_valid.
- w_m_addr  out  ADDR_W  RAM address.
- w_m_we  out  1  RAM write enable.
- w_m_wdata  out  DATA_W  RAM write data.
- w_m_rdata  in  DATA_W  RAM registered read output.

Behaviour:
- Reset: r_i_valid=0, r_d_valid=0, starvation counter r_starve=0, state S_IDLE. Grants are suppressed (both 0) during any cycle in which w_rst=1.
- State register records the access issued last cycle:
  - S_IDLE: nothing issued.
  - S_IRD: fetch read.
  - S_DRD: load.
  - S_DWR: store.
  - Next state is determined solely by this cycle's grant: i_gnt -> S_IRD; d_gnt && we -> S_DWR; d_gnt && !we -> S_DRD; no grant -> S_IDLE.
- Grant rule, evaluated each cycle:
  - Only w_i_req: grant I.
  - Only w_d_req: grant D.
  - Both requests and r_starve < STARVE_MAX: grant D.
  - Both requests and r_starve == STARVE_MAX: grant I.
  - At most one grant per cycle.
- Starvation counter r_starve (4-bit):
  - Increments on a D grant while w_i_req=1.
  - Clears on any I grant, or when w_i_req=0.
  - Saturates at STARVE_MAX.
- Memory mux: w_m_addr, w_m_we and w_m_wdata come from the granted side. With no grant: w_m_we=0 and w_m_addr holds the last issued address.
- Latency: a grant in cycle N gives r_x_valid=1 in cycle N+1, with w_x_rdata = w_m_rdata. Valid lasts exactly one cycle per grant. Both rdata outputs wire directly to w_m_rdata.
- A store to address A in cycle N followed by a read of A in N+1 must return the new data (RAM is write-first on the same port; the arbiter adds nothing).
- Back-to-back grants to the same side are allowed every cycle (full throughput, 1 access/cycle).
- Reset asserted while a read is in flight: the valid due next cycle is dropped (r_x_valid=0).
- Requests dropped without a grant are legal. The arbiter keeps no request history except r_starve.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined, adds two outputs:
  - r_i_stall_cnt  out  32: cycles with w_i_stall=1.
  - r_d_stall_cnt  out  32: cycles with w_d_stall=1.
- Both counters clear on w_rst and wrap modulo 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Fetch-only stream, addresses 0,1,2,3 requested every cycle -> w_i_gnt=1 every cycle; r_i_valid every cycle from cycle 1 carrying RAM words 0..3 in order; w_i_stall always 0.
- Both requests held continuously, STARVE_MAX=3 -> grant pattern D,D,D,I repeating; w_i_stall=1 on the three D cycles; r_starve returns to 0 after each I grant.
- Store 0xDEADBEEF to 0x010 (D grant, cycle N), then load 0x010 in cycle N+1 -> r_d_valid=1 in N+2 with w_d_rdata=0xDEADBEEF; r_d_valid stays 0 in N+1.
- Fetch grant in cycle N, w_rst=1 in cycle N+1 -> r_i_valid=0 in N+1 and N+2; no grants during reset; state S_IDLE afterwards.
- Data request alone, w_i_req deasserted -> D granted each cycle, r_starve stays 0; raising w_i_req later gets I granted after at most 3 D grants.
- With ARB_PERF_CNT_EN: 10 cycles of both requests (STARVE_MAX=3) -> r_i_stall_cnt=8, r_d_stall_cnt=2.
